// File: rtl/mesh_terminal_if.sv
// Bundle of host-side and router-side signals of a mesh terminal.
// The master modport is the terminal's view; slave is the environment's view.
interface mesh_terminal_if #(
    parameter int pck_sz = 40
);
    logic              tx_push;
    logic [pck_sz-1:0] tx_data;
    logic              tx_full;
    logic [pck_sz-1:0] data_out_i_in;
    logic              pndng_i_in;
    logic              popin;
    logic [pck_sz-1:0] data_out;
    logic              pndng;
    logic              pop;
    logic              rx_valid;
    logic [pck_sz-1:0] rx_data;
    logic              rx_ready;
    logic              rx_misroute;
    logic              tx_ovf;
    logic              tx_udf;
    logic [15:0]       tx_cnt;
    logic [15:0]       rx_cnt;
    logic [15:0]       mis_cnt;

    modport master (
        input  tx_push, tx_data, popin, data_out, pndng, rx_ready,
        output tx_full, data_out_i_in, pndng_i_in, pop, rx_valid, rx_data,
               rx_misroute, tx_ovf, tx_udf, tx_cnt, rx_cnt, mis_cnt
    );

    modport slave (
        output tx_push, tx_data, popin, data_out, pndng, rx_ready,
        input  tx_full, data_out_i_in, pndng_i_in, pop, rx_valid, rx_data,
               rx_misroute, tx_ovf, tx_udf, tx_cnt, rx_cnt, mis_cnt
    );
endinterface

// File: rtl/mesh_terminal.sv
// Mesh terminal: a TX queue feeding the router input port, and an RX queue
// filled from the router output port by a three-state pop FSM that leaves
// one idle cycle after each pop for the router's pndng to update.
module mesh_terminal #(
    parameter int         pck_sz     = 40,
    parameter int         fifo_depth = 4,
    parameter logic [3:0] id_r       = 4'd0,
    parameter logic [3:0] id_c       = 4'd0,
    parameter logic [7:0] broadcast  = {8{1'b1}}
) (
    input  logic           clk,
    input  logic           reset,
    mesh_terminal_if.master bus
);
    localparam int aw = $clog2(fifo_depth);
    localparam int cw = aw + 1;

    typedef enum logic [1:0] {IDLE, POP, GAP} rx_state_t;

    // TX queue
    logic [pck_sz-1:0] tx_mem [fifo_depth];
    logic [aw-1:0]     tx_wr_ptr, tx_rd_ptr;
    logic [cw-1:0]     tx_count;
    logic              tx_empty, tx_full_q, tx_enq, tx_deq;
    logic              tx_ovf_q, tx_udf_q;
    logic [15:0]       tx_cnt_q;

    // RX queue and FSM
    logic [pck_sz-1:0] rx_mem [fifo_depth];
    logic              rx_mis_mem [fifo_depth];
    logic [aw-1:0]     rx_wr_ptr, rx_rd_ptr;
    logic [cw-1:0]     rx_count;
    logic              rx_empty, rx_full, rx_wr, rx_rd;
    logic [15:0]       rx_cnt_q, mis_cnt_q;
    rx_state_t         state, state_nxt;
    logic              pop_int;
    logic [7:0]        dest;
    logic              misroute;

    assign tx_empty  = (tx_count == '0);
    assign tx_full_q = (tx_count == cw'(fifo_depth));
    assign tx_deq    = bus.popin && !tx_empty;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign tx_enq    = bus.tx_push && (!tx_full_q || tx_deq);

    assign rx_empty  = (rx_count == '0);
    assign rx_full   = (rx_count == cw'(fifo_depth));
    assign rx_wr     = pop_int;
    assign rx_rd     = bus.rx_ready && !rx_empty;

    assign dest      = bus.data_out[pck_sz-9 -: 8];
    assign misroute  = (dest != {id_r, id_c}) && (dest != broadcast);

    // TX pointers, occupancy, sticky error flags and dequeue counter
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            tx_ovf_q  <= 1'b0;
            tx_udf_q  <= 1'b0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_enq) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_deq) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
                tx_cnt_q  <= tx_cnt_q + 16'd1;
            end
            if (tx_enq && !tx_deq)      tx_count <= tx_count + 1'b1;
            else if (!tx_enq && tx_deq) tx_count <= tx_count - 1'b1;
            if (bus.tx_push && !tx_enq) tx_ovf_q <= 1'b1;
            if (bus.popin && tx_empty)  tx_udf_q <= 1'b1;
        end
    end

    // Queue storage for both directions
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; outputs of an empty queue are forced to zero instead.
        if (!reset && tx_enq) tx_mem[tx_wr_ptr] <= bus.tx_data;
        if (!reset && rx_wr) begin
            rx_mem[rx_wr_ptr]     <= bus.data_out;
            rx_mis_mem[rx_wr_ptr] <= misroute;
        end
    end

    // RX FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // RX FSM next state and pop strobe
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_nxt = state;
        pop_int   = 1'b0;
        case (state)
            IDLE: if (bus.pndng && !rx_full) state_nxt = POP;
            POP: begin
                pop_int   = 1'b1;
                state_nxt = GAP;
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RX pointers, occupancy and event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            rx_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (rx_wr) begin
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
                rx_cnt_q  <= rx_cnt_q + 16'd1;
                if (misroute) mis_cnt_q <= mis_cnt_q + 16'd1;
            end
            if (rx_rd) rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_wr && !rx_rd)      rx_count <= rx_count + 1'b1;
            else if (!rx_wr && rx_rd) rx_count <= rx_count - 1'b1;
        end
    end

    assign bus.tx_full       = tx_full_q;
    assign bus.pndng_i_in    = !tx_empty;
    assign bus.data_out_i_in = tx_empty ? '0 : tx_mem[tx_rd_ptr];
    assign bus.pop           = pop_int;
    assign bus.rx_valid      = !rx_empty;
    assign bus.rx_data       = rx_empty ? '0 : rx_mem[rx_rd_ptr];
    assign bus.rx_misroute   = !rx_empty && rx_mis_mem[rx_rd_ptr];
    assign bus.tx_ovf        = tx_ovf_q;
    assign bus.tx_udf        = tx_udf_q;
    assign bus.tx_cnt        = tx_cnt_q;
    assign bus.rx_cnt        = rx_cnt_q;
    assign bus.mis_cnt       = mis_cnt_q;
endmodule
